usb_fs_in_pe: RTL and testbench
===============================

# usb_fs_in_pe

USB full-speed IN protocol engine: buffers one packet per IN endpoint from the device-side endpoint logic and returns it to the host on a matching IN token. Handles DATA0/DATA1 toggling, NAK when no packet is committed, STALL, and retransmission when the host does not ACK. Sits beside the OUT protocol engine, between the packet decoder (rx token path) and the packet encoder (tx path).

## Interface
- NUM_IN_EPS, 1, IN endpoints implemented (1..16)
- MAX_IN_PACKET_SIZE, 32, bytes per endpoint buffer (power of two, ≤ 64)
- ACK_TIMEOUT, 1023, cycles to wait for handshake after tx_pkt_end (with USB_IN_ACK_TIMEOUT_EN)
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- reset_ep  in  NUM_IN_EPS  per-endpoint synchronous reset (state, toggle, buffer pointers)
- dev_addr  in  7  assigned device address
- in_ep_data_free  out  NUM_IN_EPS  endpoint buffer empty and accepting in_ep_data_put
- in_ep_data_put  in  NUM_IN_EPS  write in_ep_data into endpoint buffer (one-hot)
- in_ep_data  in  8  byte to write
- in_ep_data_done  in  NUM_IN_EPS  commit buffered bytes as one packet (may be zero-length)
- in_ep_stall  in  NUM_IN_EPS  force STALL handshake
- in_ep_acked  out  NUM_IN_EPS  1-cycle pulse when host ACKs the packet
- rx_pkt_start, rx_pkt_end, rx_pkt_valid  in  1 each  decoder strobes
- rx_pid  in  4; rx_addr  in  7; rx_endp  in  4  fields of last received packet
- tx_pkt_start  out  1  1-cycle strobe to start a packet
- tx_pid  out  4  PID for tx_pkt_start
- tx_data_avail  out  1  more payload bytes pending
- tx_data_get  in  1  encoder consumes tx_data this cycle
- tx_data  out  8  current payload byte (combinational from buffer at get pointer)
- tx_pkt_end  in  1  encoder finished sending packet

## Operation
- Token decode (valid on rx_pkt_end && rx_pkt_valid, rx_addr == dev_addr, rx_endp < NUM_IN_EPS): IN = rx_pid 4'b1001; SETUP = 4'b1101.
- Endpoint FSM per EP: READY_FOR_PKT (in_ep_data_free=1; puts increment put_addr, saturating at MAX_IN_PACKET_SIZE, further puts dropped) -> in_ep_data_done -> PKT_READY -> host ACK -> READY_FOR_PKT with put_addr=0. STALL entered whenever in_ep_stall is high (overrides); left to READY_FOR_PKT on SETUP to that EP while in_ep_stall low.
- SETUP to EP n sets data_toggle[n]=1 (control data stage starts DATA1).
- Transfer FSM: IDLE -> (IN token) RCVD_IN, latch current_endp. RCVD_IN (one cycle, tx_pkt_start=1): STALL state -> tx_pid 4'b1110, IDLE; not PKT_READY -> NAK 4'b1010, IDLE; else DATA0 4'b0011 / DATA1 4'b1011 per toggle, get_addr=0, -> SEND_DATA.
- SEND_DATA: tx_data_avail = get_addr < put_addr; tx_data_get advances get_addr; tx_pkt_end -> WAIT_ACK.
- WAIT_ACK: valid ACK (4'b0010) -> toggle flips, in_ep_acked pulse, EP -> READY_FOR_PKT, IDLE. Any other rx_pkt_end or timeout -> IDLE, packet retained, toggle unchanged (retransmitted on next IN).
- Tokens arriving outside IDLE ignored.

## Timing
- Reset: all outputs 0 except in_ep_data_free = all ones; toggles 0; all FSMs READY_FOR_PKT/IDLE.
- tx_pkt_start exactly 1 cycle after the IN token's rx_pkt_end cycle.
- in_ep_acked asserted the cycle after the ACK's rx_pkt_end.
- in_ep_data_put and in_ep_data_done same cycle: byte stored, then committed.
- reset_ep[n] mid-transfer on current_endp: EP cleared; transfer FSM returns IDLE next cycle, no ACK pulse.
- Zero-length packet: tx_data_avail stays 0 in SEND_DATA.

## Configuration
- USB_IN_ACK_TIMEOUT_EN defined: WAIT_ACK counter, returns IDLE after ACK_TIMEOUT cycles with no rx_pkt_end.
- Undefined: no counter; WAIT_ACK exits only on next rx_pkt_end (or reset).

## Structure
- Package usb_fs_pkg: PID constants (ACK, NAK, STALL, DATA0, DATA1, IN, SETUP), EP and transfer state encodings.
- Sub-module usb_fs_in_ep_buffer: NUM_IN_EPS × MAX_IN_PACKET_SIZE byte memory, write port {ep, put_addr}, read port {current_endp, get_addr}.

## Test plan
- Put 3 bytes 0xA1,0xB2,0xC3 on EP0, done; IN addr match -> tx_pid 0011, bytes in order, host ACK -> in_ep_acked[0] pulse, next packet DATA1.
- IN to EP0 with empty buffer -> tx_pid 1010, no data phase.
- in_ep_stall[0]=1, IN -> tx_pid 1110; SETUP, stall low -> READY, next packet DATA1.
- Packet sent, host returns no ACK (timeout, macro on) -> re-IN resends same bytes with same PID.
- IN with rx_addr ≠ dev_addr or rx_endp ≥ NUM_IN_EPS -> no tx_pkt_start.
- 40 puts with MAX_IN_PACKET_SIZE=32 -> 32 bytes transmitted; zero-length done -> DATA PID, tx_data_avail never high.

Source files
------------

// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: PID codes and state encodings shared by the full-speed protocol engines.
package usb_fs_pkg;

   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;

   typedef enum logic [1:0] {
      EP_READY_FOR_PKT = 2'd0,
      EP_PKT_READY     = 2'd1,
      EP_STALL         = 2'd2
   } ep_state_e;

   typedef enum logic [1:0] {
      XFER_IDLE      = 2'd0,
      XFER_RCVD_IN   = 2'd1,
      XFER_SEND_DATA = 2'd2,
      XFER_WAIT_ACK  = 2'd3
   } xfer_state_e;

   function automatic logic [3:0] data_pid(input logic toggle);
      return toggle ? PID_DATA1 : PID_DATA0;
   endfunction

endpackage

// File: rtl/usb_fs_in_pe_if.sv
// usb_fs_in_pe_if: endpoint, packet-decoder and packet-encoder signals of the IN protocol engine.
// slave = the protocol engine, master = the surrounding logic driving it.
interface usb_fs_in_pe_if #(
   parameter int NUM_IN_EPS = 1
);
   logic [NUM_IN_EPS-1:0] reset_ep;
   logic [6:0]            dev_addr;
   logic [NUM_IN_EPS-1:0] in_ep_data_free;
   logic [NUM_IN_EPS-1:0] in_ep_data_put;
   logic [7:0]            in_ep_data;
   logic [NUM_IN_EPS-1:0] in_ep_data_done;
   logic [NUM_IN_EPS-1:0] in_ep_stall;
   logic [NUM_IN_EPS-1:0] in_ep_acked;
   logic                  rx_pkt_start;
   logic                  rx_pkt_end;
   logic                  rx_pkt_valid;
   logic [3:0]            rx_pid;
   logic [6:0]            rx_addr;
   logic [3:0]            rx_endp;
   logic                  tx_pkt_start;
   logic [3:0]            tx_pid;
   logic                  tx_data_avail;
   logic                  tx_data_get;
   logic [7:0]            tx_data;
   logic                  tx_pkt_end;

   modport slave (
      input  reset_ep, dev_addr, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
      input  rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp,
      input  tx_data_get, tx_pkt_end,
      output in_ep_data_free, in_ep_acked, tx_pkt_start, tx_pid, tx_data_avail, tx_data
   );

   modport master (
      output reset_ep, dev_addr, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
      output rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp,
      output tx_data_get, tx_pkt_end,
      input  in_ep_data_free, in_ep_acked, tx_pkt_start, tx_pid, tx_data_avail, tx_data
   );
endinterface

// File: rtl/usb_fs_in_ep_buffer.sv
// usb_fs_in_ep_buffer: byte store for all IN endpoints, one write port and one
// asynchronous read port, both addressed as {endpoint, byte offset}.
module usb_fs_in_ep_buffer #(
   parameter int EW = 1,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [EW-1:0] wr_ep_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [7:0]    wr_data_i,
   input  logic [EW-1:0] rd_ep_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [7:0]    rd_data_o
);
   logic [7:0] mem_q [0:(2**(EW+AW))-1];

   // byte write from the endpoint side
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[{wr_ep_i, wr_addr_i}] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[{rd_ep_i, rd_addr_i}];
endmodule

// File: rtl/usb_fs_in_pe.sv
// usb_fs_in_pe: USB full-speed IN protocol engine, one packet buffer per IN endpoint.
// Define USB_IN_ACK_TIMEOUT_EN to abandon WAIT_ACK after ACK_TIMEOUT cycles without a handshake.
module usb_fs_in_pe
   import usb_fs_pkg::*;
#(
   parameter int NUM_IN_EPS         = 1,
   parameter int MAX_IN_PACKET_SIZE = 32,
   parameter int ACK_TIMEOUT        = 1023
) (
   input logic           clk,
   input logic           reset,
   usb_fs_in_pe_if.slave bus
);
   localparam int EW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
   localparam int AW = $clog2(MAX_IN_PACKET_SIZE);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] MAX_PKT = PW'(MAX_IN_PACKET_SIZE);
   localparam logic [4:0]    NUM_EPS = 5'(NUM_IN_EPS);

   ep_state_e             ep_state_q [NUM_IN_EPS];
   ep_state_e             ep_state_d [NUM_IN_EPS];
   logic [PW-1:0]         put_addr_q [NUM_IN_EPS];
   logic [PW-1:0]         put_addr_d [NUM_IN_EPS];
   logic [NUM_IN_EPS-1:0] toggle_q, toggle_d, acked_q, acked_d;
   xfer_state_e           xfer_q, xfer_d;
   logic [EW-1:0]         cur_ep_q, cur_ep_d;
   logic [PW-1:0]         get_addr_q, get_addr_d;

   logic                  tok_ok_s, in_tok_s, setup_tok_s, ack_s, xfer_abort_s, ack_timeout_s;
   logic [EW-1:0]         tok_ep_s, wr_ep_s;
   logic [AW-1:0]         wr_addr_s;
   logic                  wr_en_s, avail_s, pkt_start_s;
   logic [3:0]            pid_s;
   logic [7:0]            rd_data_s;
   logic [NUM_IN_EPS-1:0] free_s, setup_hit_s, ack_hit_s, wr_hit_s;

   assign tok_ok_s     = bus.rx_pkt_end && bus.rx_pkt_valid && (bus.rx_addr == bus.dev_addr)
                         && ({1'b0, bus.rx_endp} < NUM_EPS);
   assign tok_ep_s     = bus.rx_endp[EW-1:0];
   assign in_tok_s     = tok_ok_s && (bus.rx_pid == PID_IN);
   assign setup_tok_s  = tok_ok_s && (bus.rx_pid == PID_SETUP);
   assign ack_s        = (xfer_q == XFER_WAIT_ACK) && bus.rx_pkt_end && bus.rx_pkt_valid
                         && (bus.rx_pid == PID_ACK);
   assign xfer_abort_s = (xfer_q != XFER_IDLE) && bus.reset_ep[cur_ep_q];
   assign avail_s      = (xfer_q == XFER_SEND_DATA) && (get_addr_q < put_addr_q[cur_ep_q]);

`ifdef USB_IN_ACK_TIMEOUT_EN
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   logic [TW-1:0] timeout_cnt_q;

   // cycles spent waiting for the host handshake
   always_ff @(posedge clk) begin
      if (reset || (xfer_q != XFER_WAIT_ACK)) begin
         timeout_cnt_q <= '0;
      end else begin
         timeout_cnt_q <= timeout_cnt_q + 1'b1;
      end
   end

   assign ack_timeout_s = (xfer_q == XFER_WAIT_ACK) && (timeout_cnt_q == TW'(ACK_TIMEOUT - 1));
`else
   assign ack_timeout_s = 1'b0;
`endif

   // per-endpoint event decode; puts are one-hot so the write port is an OR of the hits
   always_comb begin
      wr_en_s   = 1'b0;
      wr_ep_s   = '0;
      wr_addr_s = '0;
      for (int n = 0; n < NUM_IN_EPS; n++) begin
         free_s[n]      = (ep_state_q[n] == EP_READY_FOR_PKT);
         setup_hit_s[n] = setup_tok_s && (tok_ep_s == EW'(n));
         ack_hit_s[n]   = ack_s && !xfer_abort_s && (cur_ep_q == EW'(n));
         wr_hit_s[n]    = bus.in_ep_data_put[n] && free_s[n] && !bus.reset_ep[n]
                          && !bus.in_ep_stall[n] && (put_addr_q[n] < MAX_PKT);
         wr_en_s        = wr_en_s | wr_hit_s[n];
         wr_ep_s        = wr_ep_s | ({EW{wr_hit_s[n]}} & EW'(n));
         wr_addr_s      = wr_addr_s | ({AW{wr_hit_s[n]}} & put_addr_q[n][AW-1:0]);
      end
   end

   // endpoint FSMs: reset_ep beats stall, stall beats everything else
   always_comb begin
      for (int n = 0; n < NUM_IN_EPS; n++) begin
         ep_state_d[n] = ep_state_q[n];
         put_addr_d[n] = put_addr_q[n];
         acked_d[n]    = ack_hit_s[n] && !bus.reset_ep[n];
         if (bus.reset_ep[n]) begin
            toggle_d[n] = 1'b0;
         end else if (setup_hit_s[n]) begin
            toggle_d[n] = 1'b1;
         end else if (ack_hit_s[n]) begin
            toggle_d[n] = ~toggle_q[n];
         end else begin
            toggle_d[n] = toggle_q[n];
         end
         if (bus.reset_ep[n]) begin
            ep_state_d[n] = EP_READY_FOR_PKT;
            put_addr_d[n] = '0;
         end else if (bus.in_ep_stall[n]) begin
            ep_state_d[n] = EP_STALL;
         end else begin
            case (ep_state_q[n])
               EP_READY_FOR_PKT: begin
                  if (wr_hit_s[n]) begin
                     put_addr_d[n] = put_addr_q[n] + 1'b1;
                  end else begin
                     put_addr_d[n] = put_addr_q[n];
                  end
                  if (bus.in_ep_data_done[n]) begin
                     ep_state_d[n] = EP_PKT_READY;
                  end else begin
                     ep_state_d[n] = EP_READY_FOR_PKT;
                  end
               end
               EP_PKT_READY: begin
                  if (ack_hit_s[n]) begin
                     ep_state_d[n] = EP_READY_FOR_PKT;
                     put_addr_d[n] = '0;
                  end else begin
                     ep_state_d[n] = EP_PKT_READY;
                  end
               end
               EP_STALL: begin
                  if (setup_hit_s[n]) begin
                     ep_state_d[n] = EP_READY_FOR_PKT;
                     put_addr_d[n] = '0;
                  end else begin
                     ep_state_d[n] = EP_STALL;
                  end
               end
               default: begin
                  ep_state_d[n] = EP_READY_FOR_PKT;
                  put_addr_d[n] = '0;
               end
            endcase
         end
      end
   end

   // transfer FSM next state and tx strobes
   always_comb begin
      xfer_d      = xfer_q;
      cur_ep_d    = cur_ep_q;
      get_addr_d  = get_addr_q;
      pkt_start_s = 1'b0;
      pid_s       = 4'b0000;
      if (xfer_abort_s) begin
         xfer_d = XFER_IDLE;
      end else begin
         case (xfer_q)
            XFER_IDLE: begin
               if (in_tok_s) begin
                  xfer_d   = XFER_RCVD_IN;
                  cur_ep_d = tok_ep_s;
               end else begin
                  xfer_d = XFER_IDLE;
               end
            end
            XFER_RCVD_IN: begin
               pkt_start_s = 1'b1;
               if (ep_state_q[cur_ep_q] == EP_STALL) begin
                  pid_s  = PID_STALL;
                  xfer_d = XFER_IDLE;
               end else if (ep_state_q[cur_ep_q] != EP_PKT_READY) begin
                  pid_s  = PID_NAK;
                  xfer_d = XFER_IDLE;
               end else begin
                  pid_s      = data_pid(toggle_q[cur_ep_q]);
                  get_addr_d = '0;
                  xfer_d     = XFER_SEND_DATA;
               end
            end
            XFER_SEND_DATA: begin
               if (bus.tx_data_get && avail_s) begin
                  get_addr_d = get_addr_q + 1'b1;
               end else begin
                  get_addr_d = get_addr_q;
               end
               if (bus.tx_pkt_end) begin
                  xfer_d = XFER_WAIT_ACK;
               end else begin
                  xfer_d = XFER_SEND_DATA;
               end
            end
            XFER_WAIT_ACK: begin
               if (bus.rx_pkt_end || ack_timeout_s) begin
                  xfer_d = XFER_IDLE;
               end else begin
                  xfer_d = XFER_WAIT_ACK;
               end
            end
            default: xfer_d = XFER_IDLE;
         endcase
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_q     <= XFER_IDLE;
         cur_ep_q   <= '0;
         get_addr_q <= '0;
         toggle_q   <= '0;
         acked_q    <= '0;
         for (int n = 0; n < NUM_IN_EPS; n++) begin
            ep_state_q[n] <= EP_READY_FOR_PKT;
            put_addr_q[n] <= '0;
         end
      end else begin
         xfer_q     <= xfer_d;
         cur_ep_q   <= cur_ep_d;
         get_addr_q <= get_addr_d;
         toggle_q   <= toggle_d;
         acked_q    <= acked_d;
         for (int n = 0; n < NUM_IN_EPS; n++) begin
            ep_state_q[n] <= ep_state_d[n];
            put_addr_q[n] <= put_addr_d[n];
         end
      end
   end

   usb_fs_in_ep_buffer #(
      .EW (EW),
      .AW (AW)
   ) u_buf (
      .clk       (clk),
      .wr_en_i   (wr_en_s),
      .wr_ep_i   (wr_ep_s),
      .wr_addr_i (wr_addr_s),
      .wr_data_i (bus.in_ep_data),
      .rd_ep_i   (cur_ep_q),
      .rd_addr_i (get_addr_q[AW-1:0]),
      .rd_data_o (rd_data_s)
   );

   assign bus.in_ep_data_free = free_s;
   assign bus.in_ep_acked     = acked_q;
   assign bus.tx_pkt_start    = pkt_start_s;
   assign bus.tx_pid          = pid_s;
   assign bus.tx_data_avail   = avail_s;
   assign bus.tx_data         = avail_s ? rd_data_s : 8'h00;
endmodule

// File: tb/tb_usb_fs_in_pe.sv
// tb_usb_fs_in_pe: randomized self-checking bench for usb_fs_in_pe against a queue-based
// model of one IN endpoint (packet bytes, commit flag, data toggle, stall).
module tb_usb_fs_in_pe;
   localparam int NUM_EPS     = 1;
   localparam int MAX_PKT     = 32;
   localparam int ACK_TIMEOUT = 1023;

   localparam logic [3:0] T_ACK   = 4'b0010;
   localparam logic [3:0] T_NAK   = 4'b1010;
   localparam logic [3:0] T_STALL = 4'b1110;
   localparam logic [3:0] T_DATA0 = 4'b0011;
   localparam logic [3:0] T_DATA1 = 4'b1011;
   localparam logic [3:0] T_IN    = 4'b1001;
   localparam logic [3:0] T_SETUP = 4'b1101;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] dev_addr;
   int         checks = 0;
   int         errors = 0;

   logic [7:0] m_q[$];
   bit         m_committed;
   bit         m_toggle;
   bit         m_stalled;

   usb_fs_in_pe_if #(.NUM_IN_EPS(NUM_EPS)) bus ();

   usb_fs_in_pe #(
      .NUM_IN_EPS         (NUM_EPS),
      .MAX_IN_PACKET_SIZE (MAX_PKT),
      .ACK_TIMEOUT        (ACK_TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [3:0] model_pid();
      if (m_stalled) return T_STALL;
      if (!m_committed) return T_NAK;
      return m_toggle ? T_DATA1 : T_DATA0;
   endfunction

   task automatic put_byte(input logic [7:0] b, input bit with_done);
      bus.in_ep_data_put  = 1'b1;
      bus.in_ep_data      = b;
      bus.in_ep_data_done = with_done;
      cyc();
      bus.in_ep_data_put  = 1'b0;
      bus.in_ep_data_done = 1'b0;
      if (!m_committed && !m_stalled && m_q.size() < MAX_PKT) m_q.push_back(b);
      if (with_done && !m_stalled) m_committed = 1'b1;
   endtask

   task automatic commit();
      bus.in_ep_data_done = 1'b1;
      cyc();
      bus.in_ep_data_done = 1'b0;
      if (!m_stalled) m_committed = 1'b1;
   endtask

   task automatic load_random(input int len);
      for (int i = 0; i < len; i++) put_byte(8'($urandom_range(0, 255)), 1'b0);
      commit();
   endtask

   task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
      bus.rx_pid       = pid;
      bus.rx_addr      = addr;
      bus.rx_endp      = endp;
      bus.rx_pkt_end   = 1'b1;
      bus.rx_pkt_valid = 1'b1;
      cyc();
      bus.rx_pkt_end   = 1'b0;
      bus.rx_pkt_valid = 1'b0;
   endtask

   // one IN transaction as seen by host + encoder, checked against the model
   task automatic do_in(input bit ack, input string tag);
      logic [3:0] epid;
      logic [7:0] eb[$];
      bit         data;
      epid = model_pid();
      data = !m_stalled && m_committed;
      eb   = m_q;
      send_pkt(T_IN, dev_addr, 4'd0);
      checks++;
      if (bus.tx_pkt_start !== 1'b1 || bus.tx_pid !== epid)
         begin errors++; $display("FAIL %s start/pid: got %b/%b expected 1/%b", tag, bus.tx_pkt_start, bus.tx_pid, epid); end
      cyc();
      checks++;
      if (bus.tx_pkt_start !== 1'b0)
         begin errors++; $display("FAIL %s start_len: got %b expected 0", tag, bus.tx_pkt_start); end
      for (int i = 0; i < eb.size(); i++) begin
         checks++;
         if (bus.tx_data_avail !== 1'b1 || bus.tx_data !== eb[i])
            begin errors++; $display("FAIL %s byte%0d: got avail %b data %h expected 1 %h", tag, i, bus.tx_data_avail, bus.tx_data, eb[i]); end
         bus.tx_data_get = 1'b1;
         cyc();
         bus.tx_data_get = 1'b0;
      end
      checks++;
      if (bus.tx_data_avail !== 1'b0)
         begin errors++; $display("FAIL %s avail_end: got %b expected 0", tag, bus.tx_data_avail); end
      if (data) begin
         bus.tx_pkt_end = 1'b1;
         cyc();
         bus.tx_pkt_end = 1'b0;
         if (ack) begin
            send_pkt(T_ACK, 7'd0, 4'd0);
            checks++;
            if (bus.in_ep_acked !== 1'b1 || bus.in_ep_data_free !== 1'b1)
               begin errors++; $display("FAIL %s acked: got %b free %b expected 1 1", tag, bus.in_ep_acked, bus.in_ep_data_free); end
            m_toggle    = ~m_toggle;
            m_committed = 1'b0;
            m_q.delete();
            cyc();
         end else begin
`ifdef USB_IN_ACK_TIMEOUT_EN
            repeat (ACK_TIMEOUT + 4) cyc();
`else
            send_pkt(T_NAK, 7'd0, 4'd0);
`endif
         end
         checks++;
         if (bus.in_ep_acked !== 1'b0)
            begin errors++; $display("FAIL %s acked_low: got %b expected 0", tag, bus.in_ep_acked); end
      end
   endtask

   task automatic test_reset();
      checks++;
      if (bus.in_ep_data_free !== 1'b1 || bus.in_ep_acked !== 1'b0 || bus.tx_pkt_start !== 1'b0
          || bus.tx_pid !== 4'b0000 || bus.tx_data_avail !== 1'b0 || bus.tx_data !== 8'h00)
         begin errors++; $display("FAIL reset: got free %b acked %b start %b pid %b avail %b data %h expected 1 0 0 0000 0 00",
                                  bus.in_ep_data_free, bus.in_ep_acked, bus.tx_pkt_start, bus.tx_pid, bus.tx_data_avail, bus.tx_data); end
   endtask

   task automatic test_basic();
      put_byte(8'hA1, 1'b0);
      put_byte(8'hB2, 1'b0);
      put_byte(8'hC3, 1'b0);
      commit();
      checks++;
      if (bus.in_ep_data_free !== 1'b0)
         begin errors++; $display("FAIL basic free: got %b expected 0", bus.in_ep_data_free); end
      do_in(1'b1, "basic_data0");
      load_random($urandom_range(1, 8));
      do_in(1'b1, "basic_data1");
   endtask

   task automatic test_nak();
      do_in(1'b1, "nak1");
      do_in(1'b1, "nak2");
   endtask

   task automatic test_stall();
      bus.in_ep_stall = 1'b1;
      cyc();
      m_stalled = 1'b1;
      checks++;
      if (bus.in_ep_data_free !== 1'b0)
         begin errors++; $display("FAIL stall free: got %b expected 0", bus.in_ep_data_free); end
      do_in(1'b1, "stall_hi");
      put_byte(8'h5A, 1'b0);
      bus.in_ep_stall = 1'b0;
      cyc();
      do_in(1'b1, "stall_held");
      send_pkt(T_SETUP, dev_addr, 4'd0);
      m_stalled   = 1'b0;
      m_toggle    = 1'b1;
      m_committed = 1'b0;
      m_q.delete();
      checks++;
      if (bus.in_ep_data_free !== 1'b1)
         begin errors++; $display("FAIL setup free: got %b expected 1", bus.in_ep_data_free); end
      load_random($urandom_range(1, 6));
      do_in(1'b1, "after_setup");
   endtask

   task automatic test_retransmit();
      load_random($urandom_range(1, 10));
      do_in(1'b0, "retx_first");
      do_in(1'b1, "retx_again");
   endtask

   task automatic test_addr_filter();
      logic [6:0] bad_addr;
      bad_addr = dev_addr ^ 7'($urandom_range(1, 127));
      load_random(2);
      send_pkt(T_IN, bad_addr, 4'd0);
      checks++;
      if (bus.tx_pkt_start !== 1'b0)
         begin errors++; $display("FAIL filter addr: got %b expected 0", bus.tx_pkt_start); end
      send_pkt(T_IN, dev_addr, 4'($urandom_range(1, 15)));
      checks++;
      if (bus.tx_pkt_start !== 1'b0)
         begin errors++; $display("FAIL filter endp: got %b expected 0", bus.tx_pkt_start); end
      do_in(1'b1, "filter_ok");
   endtask

   task automatic test_overflow_zlp();
      for (int i = 0; i < 40; i++) put_byte(8'($urandom_range(0, 255)), 1'b0);
      commit();
      checks++;
      if (m_q.size() != MAX_PKT)
         begin errors++; $display("FAIL model size: got %0d expected %0d", m_q.size(), MAX_PKT); end
      do_in(1'b1, "overflow");
      commit();
      do_in(1'b1, "zlp");
   endtask

   task automatic test_back_to_back();
      put_byte(8'($urandom_range(0, 255)), 1'b0);
      put_byte(8'($urandom_range(0, 255)), 1'b1);
      do_in(1'b1, "put_done_same");
      for (int k = 0; k < 10; k++) begin
         load_random($urandom_range(0, 40));
         if ($urandom_range(0, 2) == 0) do_in(1'b0, "rand_noack");
         do_in(1'b1, "rand");
      end
   endtask

   task automatic test_reset_ep();
      load_random(3);
      send_pkt(T_IN, dev_addr, 4'd0);
      cyc();
      checks++;
      if (bus.tx_data_avail !== 1'b1)
         begin errors++; $display("FAIL rstep pre avail: got %b expected 1", bus.tx_data_avail); end
      bus.reset_ep = 1'b1;
      cyc();
      bus.reset_ep = 1'b0;
      m_q.delete();
      m_committed = 1'b0;
      m_toggle    = 1'b0;
      checks++;
      if (bus.tx_data_avail !== 1'b0 || bus.in_ep_data_free !== 1'b1 || bus.in_ep_acked !== 1'b0)
         begin errors++; $display("FAIL rstep: got avail %b free %b acked %b expected 0 1 0", bus.tx_data_avail, bus.in_ep_data_free, bus.in_ep_acked); end
      do_in(1'b1, "rstep_nak");
      load_random(2);
      do_in(1'b1, "rstep_data0");
   endtask

   initial begin
      reset               = 1'b1;
      dev_addr            = 7'($urandom_range(1, 127));
      bus.dev_addr        = dev_addr;
      bus.reset_ep        = '0;
      bus.in_ep_data_put  = '0;
      bus.in_ep_data      = 8'h00;
      bus.in_ep_data_done = '0;
      bus.in_ep_stall     = '0;
      bus.rx_pkt_start    = 1'b0;
      bus.rx_pkt_end      = 1'b0;
      bus.rx_pkt_valid    = 1'b0;
      bus.rx_pid          = 4'b0000;
      bus.rx_addr         = 7'd0;
      bus.rx_endp         = 4'd0;
      bus.tx_data_get     = 1'b0;
      bus.tx_pkt_end      = 1'b0;
      m_committed         = 1'b0;
      m_toggle            = 1'b0;
      m_stalled           = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      test_reset();
      test_basic();
      test_nak();
      test_stall();
      test_retransmit();
      test_addr_filter();
      test_overflow_zlp();
      test_back_to_back();
      test_reset_ep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
